ins_loader: RTL and testbench

- Boot-time instruction loader that sits directly upstream of the single-cycle core's fetch stage.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the fetch stage's instruction memory through the W_Ins/WE write path, one word per address.
- Holds the core in reset while loading, and releases it once the image is fully written.

---
 rtl/ins_loader_pkg.sv | 26 ++
 rtl/ins_csum.sv | 46 ++++
 rtl/ins_loader.sv | 216 +++++++++++++++++++++
 tb/tb_ins_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_loader_pkg.sv
// ins_loader_pkg: shared definitions for the boot-time instruction loader.
//   state_e    - loader state encoding (CHECK only reachable with INS_LOADER_CHECKSUM_EN)
//   DEF_ADDR_W - default instruction-memory word-address width
//   MAX_LEN    - largest legal image length for DEF_ADDR_W (2^DEF_ADDR_W words)
//   CSUM_W     - checksum accumulator width
//   max_len()  - image capacity for an arbitrary address width
package ins_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERR
    } state_e;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned CSUM_W     = 32;

    function automatic int unsigned max_len(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int unsigned MAX_LEN = max_len(DEF_ADDR_W);

endpackage

// File: rtl/ins_csum.sv
// ins_csum: 32-bit wrap-around accumulator for the image checksum.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   clr_i  - clear accumulator to zero
//   add_i  - add data_i into the accumulator
//   data_i - word to add / candidate check word
//   zero_o - high when accumulator + data_i is zero (mod 2^32)
module ins_csum
    import ins_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [CSUM_W-1:0] data_i,
    output logic              zero_o
);

    logic [CSUM_W-1:0] acc_q;
    logic [CSUM_W-1:0] acc_d;
    logic [CSUM_W-1:0] sum_w;

    // The check word is compared on the fly rather than accumulated first,
    // so the verdict is available on the cycle the check word is accepted.
    assign sum_w  = acc_q + data_i;
    assign zero_o = (sum_w == '0);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum_w;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ins_loader.sv
// ins_loader: boot-time instruction loader in front of the core's fetch stage.
// Streams 32-bit words (valid/ready) into instruction memory, one word per
// address, holding the core in reset until the image is fully written.
// Optional macro INS_LOADER_CHECKSUM_EN: after the image, one extra check word
// is accepted (never written); image sum + check word must be 0 mod 2^32.
// Ports:
//   CLK, RST      - clock, asynchronous active-low reset
//   Start, Len    - load request and image length in words
//   S_Valid/S_Data/S_Ready - input word stream handshake
//   W_Ins/W_Addr/WE - instruction-memory write port
//   Core_RST      - active-low core reset (0 holds the core)
//   Busy/Done/Err - status: loading, image running, sticky error
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    input  logic              S_Valid,
    input  logic [31:0]       S_Data,
    output logic              S_Ready,
    output logic [31:0]       W_Ins,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              WE,
    output logic              Core_RST,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(max_len(ADDR_W));
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [31:0]       w_ins_q, w_ins_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              we_q, we_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              core_rst_q, core_rst_d;
    logic              xfer;
    logic              last;

    assign xfer = S_Valid && s_ready_q;
    // cnt is one bit wider than the address so a full-depth image never wraps.
    assign last = (cnt_q == (len_q - ONE));

`ifdef INS_LOADER_CHECKSUM_EN
    logic csum_clr;
    logic csum_add;
    logic csum_zero;

    ins_csum u_csum (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (csum_clr),
        .add_i  (csum_add),
        .data_i (S_Data),
        .zero_o (csum_zero)
    );
`endif

    // Status outputs are computed from the next state so that, once
    // registered, they line up exactly with the state they describe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        w_ins_d    = w_ins_q;
        w_addr_d   = w_addr_q;
        we_d       = 1'b0;
        s_ready_d  = s_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        core_rst_d = core_rst_q;
`ifdef INS_LOADER_CHECKSUM_EN
        csum_clr   = 1'b0;
        csum_add   = 1'b0;
`endif

        unique case (state_q)
            IDLE, ERR, RUN: begin
                // RUN releases the core one cycle after entry, i.e. after the
                // final write strobe has been presented to memory.
                core_rst_d = (state_q == RUN);
                if (Start) begin
                    core_rst_d = 1'b0;
                    if (Len > LEN_MAX) begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b0;
                    end else begin
                        err_d = 1'b0;
                        cnt_d = '0;
                        len_d = Len;
`ifdef INS_LOADER_CHECKSUM_EN
                        csum_clr = 1'b1;
`endif
                        if (Len == '0) begin
`ifdef INS_LOADER_CHECKSUM_EN
                            state_d   = CHECK;
                            s_ready_d = 1'b1;
                            busy_d    = 1'b1;
                            done_d    = 1'b0;
`else
                            state_d   = RUN;
                            s_ready_d = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
`endif
                        end else begin
                            state_d   = LOAD;
                            s_ready_d = 1'b1;
                            busy_d    = 1'b1;
                            done_d    = 1'b0;
                        end
                    end
                end
            end

            LOAD: begin
                if (xfer) begin
                    w_ins_d  = S_Data;
                    w_addr_d = cnt_q[ADDR_W-1:0];
                    we_d     = 1'b1;
                    cnt_d    = cnt_q + ONE;
`ifdef INS_LOADER_CHECKSUM_EN
                    csum_add = 1'b1;
`endif
                    if (last) begin
`ifdef INS_LOADER_CHECKSUM_EN
                        state_d   = CHECK;
`else
                        state_d   = RUN;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
`endif
                    end
                end
            end

`ifdef INS_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    s_ready_d = 1'b0;
                    busy_d    = 1'b0;
                    if (csum_zero) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d    = IDLE;
                s_ready_d  = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                core_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            w_ins_q    <= '0;
            w_addr_q   <= '0;
            we_q       <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            w_ins_q    <= w_ins_d;
            w_addr_q   <= w_addr_d;
            we_q       <= we_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign S_Ready  = s_ready_q;
    assign W_Ins    = w_ins_q;
    assign W_Addr   = w_addr_q;
    assign WE       = we_q;
    assign Core_RST = core_rst_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: scoreboard bench for ins_loader. Stimulus pushes the expected
// memory writes (address = word index, data = image word) into a queue; a
// monitor pops and compares on every WE strobe. Image outcome (run vs error)
// comes from a plain-arithmetic model of the load rules.
// Honours INS_LOADER_CHECKSUM_EN the same way the design does.
module tb_ins_loader;

    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              Start;
    logic [ADDR_W:0]   Len;
    logic              S_Valid;
    logic [31:0]       S_Data;
    logic              S_Ready;
    logic [31:0]       W_Ins;
    logic [ADDR_W-1:0] W_Addr;
    logic              WE;
    logic              Core_RST;
    logic              Busy;
    logic              Done;
    logic              Err;

    always #5 CLK = ~CLK;

    ins_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Len      (Len),
        .S_Valid  (S_Valid),
        .S_Data   (S_Data),
        .S_Ready  (S_Ready),
        .W_Ins    (W_Ins),
        .W_Addr   (W_Addr),
        .WE       (WE),
        .Core_RST (Core_RST),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] img [0:255];

`ifdef INS_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        wr_t e;
        if (WE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("we_without_expected_write", 32'(WE), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("w_addr", 32'(W_Addr), 32'(e.addr));
                chk("w_ins", W_Ins, e.data);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; issues a one-cycle Start.
    task automatic do_start(input logic [ADDR_W:0] l);
        Start = 1'b1;
        Len   = l;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    // Streams img[0..len-1]; S_Valid pattern random (pct) or alternating.
    task automatic stream(input int len, input int pct, input bit toggle, input bit start_last);
        int  i    = 0;
        int  miss = 0;
        bit  v;
        bit  ph   = 1'b1;
        wr_t e;
        while (i < len) begin
            if (toggle) begin
                v  = ph;
                ph = ~ph;
            end else begin
                v = (miss >= 6) || ($urandom_range(0, 99) < pct);
            end
            miss    = v ? 0 : miss + 1;
            S_Valid = v;
            S_Data  = v ? img[i] : $urandom;
            if (start_last && v && (i == len - 1)) begin
                Start = 1'b1;
                Len   = 5;
            end
            @(negedge CLK);
            chk("s_ready_during_load", 32'(S_Ready), 32'd1);
            @(posedge CLK); #1;
            Start = 1'b0;
            if (v) begin
                e.addr = ADDR_W'(i);
                e.data = img[i];
                sb.push_back(e);
                i++;
            end
        end
        S_Valid = 1'b0;
    endtask

    // Full load from IDLE/RUN/ERR and the expected end-of-image behaviour.
    task automatic run_image(input int len, input int pct, input bit toggle,
                             input bit start_last, input logic [31:0] ck);
        logic [31:0] s;
        bit          good;
        s = ck;
        for (int i = 0; i < len; i++) s = s + img[i];
        good = CSUM ? (s == 32'd0) : 1'b1;

        do_start(len[ADDR_W:0]);
        if (len > 0) begin
            @(negedge CLK);
            chk("start_busy", 32'(Busy), 32'd1);
            chk("start_core_held", 32'(Core_RST), 32'd0);
            chk("start_err_cleared", 32'(Err), 32'd0);
            chk("start_done_low", 32'(Done), 32'd0);
            @(posedge CLK); #1;
            stream(len, pct, toggle, start_last);
        end
        @(negedge CLK);
        if (CSUM) begin
            chk("check_busy", 32'(Busy), 32'd1);
            chk("check_ready", 32'(S_Ready), 32'd1);
            chk("check_core_held", 32'(Core_RST), 32'd0);
            S_Valid = 1'b1;
            S_Data  = ck;
            @(posedge CLK); #1;
            S_Valid = 1'b0;
            @(negedge CLK);
            chk("verdict_done", 32'(Done), 32'(good));
            chk("verdict_err", 32'(Err), 32'(!good));
            chk("verdict_core_held", 32'(Core_RST), 32'd0);
            chk("verdict_busy", 32'(Busy), 32'd0);
            @(negedge CLK);
            chk("core_release", 32'(Core_RST), 32'(good));
        end else begin
            chk("end_done", 32'(Done), 32'd1);
            chk("end_busy", 32'(Busy), 32'd0);
            chk("end_ready", 32'(S_Ready), 32'd0);
            chk("end_core_held", 32'(Core_RST), 32'd0);
            @(negedge CLK);
            chk("core_release", 32'(Core_RST), 32'd1);
            chk("run_no_we", 32'(WE), 32'd0);
            chk("run_busy", 32'(Busy), 32'd0);
        end
        @(posedge CLK); #1;
    endtask

    function automatic logic [31:0] neg_sum(input int len);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < len; i++) s = s + img[i];
        return -s;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_we"}, 32'(WE), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_ready"}, 32'(S_Ready), 32'd0);
        chk({tag, "_core"}, 32'(Core_RST), 32'd0);
        chk({tag, "_addr"}, 32'(W_Addr), 32'd0);
        chk({tag, "_ins"}, W_Ins, 32'd0);
    endtask

    initial begin
        RST = 1'b0; Start = 1'b0; Len = '0; S_Valid = 1'b0; S_Data = '0;
        @(negedge CLK);
        check_reset_values("reset");
        @(posedge CLK); #1;
        RST = 1'b1;

        // Directed three-word image, back-to-back.
        img[0] = 32'h2008_0005; img[1] = 32'h2009_0007; img[2] = 32'h0109_5020;
        run_image(3, 100, 1'b0, 1'b0, neg_sum(3));

        // Two words with valid toggling 1,0,1.
        img[0] = $urandom; img[1] = $urandom;
        run_image(2, 0, 1'b1, 1'b0, neg_sum(2));

        // Length overflow, then recovery.
        do_start(9'd257);
        @(negedge CLK);
        chk("ovf_err", 32'(Err), 32'd1);
        chk("ovf_busy", 32'(Busy), 32'd0);
        chk("ovf_done", 32'(Done), 32'd0);
        repeat (3) begin
            @(negedge CLK);
            chk("ovf_core_held", 32'(Core_RST), 32'd0);
        end
        @(posedge CLK); #1;
        img[0] = $urandom;
        run_image(1, 100, 1'b0, 1'b0, neg_sum(1));

        // Reset after two of four words.
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        do_start(9'd4);
        @(posedge CLK); #1;
        stream(2, 100, 1'b0, 1'b0);
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("abort_we", 32'(WE), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_core", 32'(Core_RST), 32'd0);
        chk("abort_ready", 32'(S_Ready), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check_reset_values("post_abort");
        @(posedge CLK); #1;

        // Load then reload from RUN with a single word.
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_image(3, 70, 1'b0, 1'b0, neg_sum(3));
        img[0] = $urandom;
        run_image(1, 100, 1'b0, 1'b0, neg_sum(1));

        // Checksum vectors (plain loads in the default build).
        img[0] = 32'h1; img[1] = 32'h2;
        run_image(2, 100, 1'b0, 1'b0, 32'hFFFF_FFFD);
        run_image(2, 100, 1'b0, 1'b0, 32'h0);

        // Randomized images, checksums good or corrupted.
        for (int t = 0; t < 8; t++) begin
            int          l;
            logic [31:0] ck;
            l = $urandom_range(1, 12);
            for (int i = 0; i < l; i++) img[i] = $urandom;
            ck = ($urandom_range(0, 1) == 1) ? neg_sum(l) : $urandom;
            run_image(l, 60, 1'b0, 1'b0, ck);
        end

        // Start coincident with the final transfer is ignored.
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        run_image(4, 100, 1'b0, 1'b1, neg_sum(4));

        // Empty image.
        run_image(0, 100, 1'b0, 1'b0, 32'h0);

        // Full-depth image.
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        run_image(256, 100, 1'b0, 1'b0, neg_sum(256));

        repeat (2) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
